master_start_sync: RTL and testbench
====================================

// Module: master_start_sync
// PURPOSE
//  Radar burst synchroniser (48 MHz domain). Keeps a 64-bit system time that is presettable on a 1 Hz mark.
//  Latches a burst descriptor on WR_DATA and hands the DDS chirp settings to the 96 MHz DDS over a REQ/ACK handshake.
//  At MEM_TIME_START it generates N transmit (En_Iz) / receive (En_Pr) windows with blanking gaps, plus DDS_start.
// PARAMETERS
//  none (all widths fixed)
// PORTS
//  CLK                 in   1   48 MHz clock, sole clock
//  RESET               in   1   asynchronous, active-low reset
//  SYS_TIME            in   64  preset value for system time
//  SYS_TIME_UPDATE     in   1   arms preset on next T1hz rising edge
//  T1hz                in   1   1 Hz mark (async level, synchronise 2FF)
//  WR_DATA             in   1   descriptor write strobe (rising edge active)
//  MEM_DDS_freq        in   48  chirp start frequency word
//  MEM_DDS_delta_freq  in   48  chirp frequency step
//  MEM_DDS_delta_rate  in   32  chirp step rate
//  MEM_TIME_START      in   64  system time of burst start
//  MEM_N_impuls        in   16  number of Ti/Tp intervals
//  MEM_TYPE_impulse    in   2   0 non-coherent, 1 coherent (2,3 treated as 1)
//  MEM_Interval_Ti     in   32  transmit window length, cycles
//  MEM_Interval_Tp     in   32  receive window length, cycles
//  MEM_Tblank1         in   32  gap Ti->Tp, cycles
//  MEM_Tblank2         in   32  gap Tp->next Ti, cycles
//  ACK                 in   1   DDS-domain acknowledge (synchronise 2FF)
//  DDS_freq            out  48  registered copy to DDS
//  DDS_delta_freq      out  48  registered copy to DDS
//  DDS_delta_rate      out  32  registered copy to DDS
//  REQ                 out  1   DDS data-valid request
//  DDS_start           out  1   DDS run enable
//  SYS_TIME_UPDATE_OK  out  1   preset happened
//  En_Iz               out  1   transmit window
//  En_Pr               out  1   receive window
// BEHAVIOUR
//  Reset: all outputs 0; sys_time=0; FSM IDLE; descriptor registers 0.
//  sys_time: +1 every CLK, wraps modulo 2^64.
//   - If SYS_TIME_UPDATE=1 on a synchronised T1hz rising edge: next sys_time=SYS_TIME and SYS_TIME_UPDATE_OK<=1.
//   - OK clears when SYS_TIME_UPDATE=0.
//  WR_DATA rising edge while FSM IDLE:
//   - copy all MEM_* into shadow registers.
//   - DDS_* outputs<=shadow.
//   - REQ<=1, then FSM LOAD.
//   - WR_DATA edge in any other state is ignored.
//  LOAD: hold REQ until synced ACK=1, then REQ<=0. Go to WAIT when synced ACK returns to 0.
//   - If N=0, return to IDLE instead of WAIT.
//  WAIT: when sys_time >= shadow TIME_START, go to TI.
//   - A start time already in the past starts immediately.
//  TI: En_Iz=1 and DDS_start=1 for exactly Ti cycles; then BL1 (Tblank1 cycles), PR (En_Pr=1, Tp cycles), BL2 (Tblank2 cycles).
//   - After BL2, decrement count; if count>0 go to TI, else IDLE.
//   - En_Iz rises 1 CLK after the cycle in which the start condition is true.
//   - A length of 0 skips its phase (0 cycles).
//  DDS_start:
//   - TYPE 0: high only in TI states. Each rise restarts the chirp from DDS_freq.
//   - TYPE 1: high from first TI through end of last BL2 (coherent, no restart).
//   - Low in IDLE.
//  En_Iz and En_Pr are never high together. All outputs are registered.
//  Async reset mid-burst: immediate return to the reset state; the burst is lost.
// TESTING
//  1. RESET low pulse, SYS_TIME_UPDATE=1, T1hz rise, SYS_TIME=0 -> sys_time=0 next cycle, SYS_TIME_UPDATE_OK=1; drop UPDATE -> OK=0.
//  2. WR with freq 0x1000000000/step 0x100000/rate 0x100 -> DDS_* take these values, REQ=1 until ACK, cleared after ACK.
//  3. TIME_START=0x12C0, N=2, TYPE=1, Ti=Tp=0x1800, blanks=0x180 -> En_Iz at cycle 4801 for 6144 cycles, 384 gap, En_Pr 6144, 384 gap, repeat once; DDS_start high 26112 cycles.
//  4. TIME_START=0x1380B, N=4, TYPE=0, Ti=Tp=0x800, blanks=0x80 -> 4 En_Iz pulses of 2048 cycles with period 4352; DDS_start toggles with En_Iz.
//  5. WR during an active burst -> ignored; N=0 with WR -> handshake only, no En_Iz.
//  6. TIME_START already passed at WR -> burst begins right after handshake completes.

Source files
------------

// File: rtl/master_start_sync.sv
// Radar burst synchroniser: keeps 64-bit system time with 1 Hz preset,
// latches a burst descriptor, hands chirp settings to the DDS over REQ/ACK
// and generates the transmit/receive window sequence for N intervals.
module master_start_sync (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] SYS_TIME,
    input  logic        SYS_TIME_UPDATE,
    input  logic        T1hz,
    input  logic        WR_DATA,
    input  logic [47:0] MEM_DDS_freq,
    input  logic [47:0] MEM_DDS_delta_freq,
    input  logic [31:0] MEM_DDS_delta_rate,
    input  logic [63:0] MEM_TIME_START,
    input  logic [15:0] MEM_N_impuls,
    input  logic [1:0]  MEM_TYPE_impulse,
    input  logic [31:0] MEM_Interval_Ti,
    input  logic [31:0] MEM_Interval_Tp,
    input  logic [31:0] MEM_Tblank1,
    input  logic [31:0] MEM_Tblank2,
    input  logic        ACK,
    output logic [47:0] DDS_freq,
    output logic [47:0] DDS_delta_freq,
    output logic [31:0] DDS_delta_rate,
    output logic        REQ,
    output logic        DDS_start,
    output logic        SYS_TIME_UPDATE_OK,
    output logic        En_Iz,
    output logic        En_Pr
);

    // The four burst phases occupy codes 4..7 so the low two bits index the phase.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_REL  = 3'd2,
        S_WAIT = 3'd3,
        S_TI   = 3'd4,
        S_BL1  = 3'd5,
        S_PR   = 3'd6,
        S_BL2  = 3'd7
    } state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_cnt, w_cnt_nx;
    logic [15:0] r_num, w_num_nx;
    logic        r_req, w_req_nx;
    logic        w_load;
    logic [2:0]  w_seek;
    logic        w_enter;

    logic        r_t1_s1, r_t1_s2, r_t1_s3;
    logic        r_ack_s1, r_ack_s2;
    logic        r_wr_d;
    logic        w_t1_rise, w_wr_rise;

    logic [63:0] r_sys_time;
    logic        r_ok;

    logic [63:0] r_start;
    logic [1:0]  r_type;
    logic [31:0] r_ti, r_tp, r_tb1, r_tb2;
    logic [47:0] r_dds_freq, r_dds_dfreq;
    logic [31:0] r_dds_rate;
    logic        r_en_iz, r_en_pr, r_dds_start;

    logic [3:0]  w_nz;
    logic [1:0]  w_cur_phase;
    logic        w_coh;

    // Lowest phase index >= from whose length is non-zero; 4 means none left.
    function automatic logic [2:0] first_nz(input logic [2:0] from, input logic [3:0] nz);
        logic [2:0] res;
        res = 3'd4;
        for (int k = 3; k >= 0; k--) begin
            if ((k >= int'(from)) && nz[k]) res = 3'(k);
        end
        return res;
    endfunction

    assign w_t1_rise   = r_t1_s2 & ~r_t1_s3;
    assign w_wr_rise   = WR_DATA & ~r_wr_d;
    assign w_nz        = {r_tb2 != 32'd0, r_tp != 32'd0, r_tb1 != 32'd0, r_ti != 32'd0};
    assign w_cur_phase = r_state[1:0];
    assign w_coh       = (r_type != 2'd0);

    // Double-flop synchronisers for T1hz and ACK plus edge history for T1hz and WR_DATA.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_t1_s1  <= 1'b0;
            r_t1_s2  <= 1'b0;
            r_t1_s3  <= 1'b0;
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
            r_wr_d   <= 1'b0;
        end else begin
            r_t1_s1  <= T1hz;
            r_t1_s2  <= r_t1_s1;
            r_t1_s3  <= r_t1_s2;
            r_ack_s1 <= ACK;
            r_ack_s2 <= r_ack_s1;
            r_wr_d   <= WR_DATA;
        end
    end

    // Free-running system time, presettable on the synchronised 1 Hz rising edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sys_time <= 64'd0;
            r_ok       <= 1'b0;
        end else if (SYS_TIME_UPDATE && w_t1_rise) begin
            r_sys_time <= SYS_TIME;
            r_ok       <= 1'b1;
        end else begin
            r_sys_time <= r_sys_time + 64'd1;
            if (!SYS_TIME_UPDATE) r_ok <= 1'b0;
        end
    end

    // Next-state logic: handshake, start-time wait and phase sequencing with zero-length skip.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_num_nx   = r_num;
        w_req_nx   = r_req;
        w_load     = 1'b0;
        w_seek     = 3'd4;
        w_enter    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_rise) begin
                    w_load     = 1'b1;
                    w_num_nx   = MEM_N_impuls;
                    w_req_nx   = 1'b1;
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_ack_s2) begin
                    w_req_nx   = 1'b0;
                    w_state_nx = S_REL;
                end
            end
            S_REL: begin
                if (!r_ack_s2) w_state_nx = (r_num == 16'd0) ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (r_sys_time >= r_start) begin
                    w_seek  = first_nz(3'd0, w_nz);
                    w_enter = 1'b1;
                end
            end
            default: begin
                if (r_cnt == 32'd0) begin
                    w_seek = first_nz({1'b0, w_cur_phase} + 3'd1, w_nz);
                    if (w_seek[2]) begin
                        if (r_num > 16'd1) begin
                            w_num_nx = r_num - 16'd1;
                            w_seek   = first_nz(3'd0, w_nz);
                        end else begin
                            w_num_nx = 16'd0;
                        end
                    end
                    w_enter = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 32'd1;
                end
            end
        endcase
        if (w_enter) begin
            if (w_seek[2]) begin
                w_state_nx = S_IDLE;
            end else begin
                w_state_nx = state_t'({1'b1, w_seek[1:0]});
                case (w_seek[1:0])
                    2'd0:    w_cnt_nx = r_ti - 32'd1;
                    2'd1:    w_cnt_nx = r_tb1 - 32'd1;
                    2'd2:    w_cnt_nx = r_tp - 32'd1;
                    default: w_cnt_nx = r_tb2 - 32'd1;
                endcase
            end
        end
    end

    // State register and window outputs, registered from the next state so they align with it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= 32'd0;
            r_num       <= 16'd0;
            r_req       <= 1'b0;
            r_en_iz     <= 1'b0;
            r_en_pr     <= 1'b0;
            r_dds_start <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_num       <= w_num_nx;
            r_req       <= w_req_nx;
            r_en_iz     <= (w_state_nx == S_TI);
            r_en_pr     <= (w_state_nx == S_PR);
            r_dds_start <= w_coh ? (w_state_nx inside {S_TI, S_BL1, S_PR, S_BL2})
                                 : (w_state_nx == S_TI);
        end
    end

    // Descriptor shadow registers and DDS copies, captured on an accepted write.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_start     <= 64'd0;
            r_type      <= 2'd0;
            r_ti        <= 32'd0;
            r_tp        <= 32'd0;
            r_tb1       <= 32'd0;
            r_tb2       <= 32'd0;
            r_dds_freq  <= 48'd0;
            r_dds_dfreq <= 48'd0;
            r_dds_rate  <= 32'd0;
        end else if (w_load) begin
            r_start     <= MEM_TIME_START;
            r_type      <= MEM_TYPE_impulse;
            r_ti        <= MEM_Interval_Ti;
            r_tp        <= MEM_Interval_Tp;
            r_tb1       <= MEM_Tblank1;
            r_tb2       <= MEM_Tblank2;
            r_dds_freq  <= MEM_DDS_freq;
            r_dds_dfreq <= MEM_DDS_delta_freq;
            r_dds_rate  <= MEM_DDS_delta_rate;
        end
    end

    assign DDS_freq           = r_dds_freq;
    assign DDS_delta_freq     = r_dds_dfreq;
    assign DDS_delta_rate     = r_dds_rate;
    assign REQ                = r_req;
    assign DDS_start          = r_dds_start;
    assign SYS_TIME_UPDATE_OK = r_ok;
    assign En_Iz              = r_en_iz;
    assign En_Pr              = r_en_pr;

endmodule

// File: tb/tb_master_start_sync.sv
// Self-checking bench for master_start_sync: descriptor table plus directed burst sequences.
module tb_master_start_sync;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [63:0] SYS_TIME;
    logic        SYS_TIME_UPDATE;
    logic        T1hz;
    logic        WR_DATA;
    logic [47:0] MEM_DDS_freq, MEM_DDS_delta_freq;
    logic [31:0] MEM_DDS_delta_rate;
    logic [63:0] MEM_TIME_START;
    logic [15:0] MEM_N_impuls;
    logic [1:0]  MEM_TYPE_impulse;
    logic [31:0] MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2;
    logic        ACK;
    logic [47:0] DDS_freq, DDS_delta_freq;
    logic [31:0] DDS_delta_rate;
    logic        REQ, DDS_start, SYS_TIME_UPDATE_OK, En_Iz, En_Pr;

    master_start_sync dut (
        .CLK(CLK), .RESET(RESET), .SYS_TIME(SYS_TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
        .T1hz(T1hz), .WR_DATA(WR_DATA), .MEM_DDS_freq(MEM_DDS_freq),
        .MEM_DDS_delta_freq(MEM_DDS_delta_freq), .MEM_DDS_delta_rate(MEM_DDS_delta_rate),
        .MEM_TIME_START(MEM_TIME_START), .MEM_N_impuls(MEM_N_impuls),
        .MEM_TYPE_impulse(MEM_TYPE_impulse), .MEM_Interval_Ti(MEM_Interval_Ti),
        .MEM_Interval_Tp(MEM_Interval_Tp), .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2),
        .ACK(ACK), .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq),
        .DDS_delta_rate(DDS_delta_rate), .REQ(REQ), .DDS_start(DDS_start),
        .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK), .En_Iz(En_Iz), .En_Pr(En_Pr)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [47:0] freq;
        logic [47:0] dfreq;
        logic [31:0] rate;
        int          n;
        int          typ;
        int          ti, b1, tp, b2;
        int          exp_iz, exp_pr, exp_ds;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Write a descriptor and act as the DDS side of the handshake; returns the cycle ACK dropped.
    task automatic do_write(input string tag, input logic [47:0] freq, input logic [47:0] dfreq,
                            input logic [31:0] rate, input logic [63:0] start, input int n,
                            input int typ, input int ti, input int b1, input int tp, input int b2,
                            output int c_ack0);
        int k;
        @(negedge CLK);
        MEM_DDS_freq       = freq;
        MEM_DDS_delta_freq = dfreq;
        MEM_DDS_delta_rate = rate;
        MEM_TIME_START     = start;
        MEM_N_impuls       = 16'(n);
        MEM_TYPE_impulse   = 2'(typ);
        MEM_Interval_Ti    = 32'(ti);
        MEM_Tblank1        = 32'(b1);
        MEM_Interval_Tp    = 32'(tp);
        MEM_Tblank2        = 32'(b2);
        WR_DATA            = 1'b1;
        @(negedge CLK);
        WR_DATA = 1'b0;
        k = 0;
        while (REQ !== 1'b1 && k < 20) begin @(negedge CLK); k++; end
        chk({tag, "_req_set"}, 64'(REQ), 64'd1);
        chk({tag, "_dds_freq"}, 64'(DDS_freq), 64'(freq));
        chk({tag, "_dds_dfreq"}, 64'(DDS_delta_freq), 64'(dfreq));
        chk({tag, "_dds_rate"}, 64'(DDS_delta_rate), 64'(rate));
        repeat (3) @(negedge CLK);
        chk({tag, "_req_hold"}, 64'(REQ), 64'd1);
        ACK = 1'b1;
        k = 0;
        while (REQ !== 1'b0 && k < 20) begin @(negedge CLK); k++; end
        chk({tag, "_req_clr"}, 64'(REQ), 64'd0);
        @(negedge CLK);
        ACK = 1'b0;
        c_ack0 = cyc;
    endtask

    // Compare every cycle of a burst against a period/offset model starting at start_cyc.
    task automatic check_burst(input string tag, input int start_cyc, input int n, input int typ,
                               input int ti, input int b1, input int tp, input int b2,
                               input bit inject_wr);
        int p, total, r, early, e_iz_err, e_pr_err, e_ds_err, ovl, ds_cnt, req_cnt;
        logic e_iz, e_pr, e_ds;
        p = ti + b1 + tp + b2;
        total = n * p;
        early = 0; e_iz_err = 0; e_pr_err = 0; e_ds_err = 0; ovl = 0; ds_cnt = 0; req_cnt = 0;
        chk({tag, "_not_late"}, 64'(cyc <= start_cyc), 64'd1);
        while (cyc < start_cyc) begin
            if (En_Iz || En_Pr || DDS_start) early++;
            @(negedge CLK);
        end
        for (int t = 0; t < total + 8; t++) begin
            e_iz = 1'b0; e_pr = 1'b0; e_ds = 1'b0;
            if (p > 0 && t < total) begin
                r = t % p;
                e_iz = (r < ti);
                e_pr = (r >= ti + b1) && (r < ti + b1 + tp);
                e_ds = (typ != 0) ? 1'b1 : e_iz;
            end
            if (En_Iz !== e_iz) e_iz_err++;
            if (En_Pr !== e_pr) e_pr_err++;
            if (DDS_start !== e_ds) e_ds_err++;
            if (En_Iz && En_Pr) ovl++;
            if (DDS_start) ds_cnt++;
            if (REQ) req_cnt++;
            if (inject_wr && t == 100) begin
                MEM_DDS_freq     = 48'hABCD_EF01_2345;
                MEM_Interval_Ti  = 32'd7;
                MEM_N_impuls     = 16'd1;
                MEM_TYPE_impulse = 2'd1;
                WR_DATA          = 1'b1;
            end
            if (inject_wr && t == 101) WR_DATA = 1'b0;
            @(negedge CLK);
        end
        chk({tag, "_early_outputs"}, 64'(early), 64'd0);
        chk({tag, "_en_iz_wave_errs"}, 64'(e_iz_err), 64'd0);
        chk({tag, "_en_pr_wave_errs"}, 64'(e_pr_err), 64'd0);
        chk({tag, "_dds_start_wave_errs"}, 64'(e_ds_err), 64'd0);
        chk({tag, "_overlap"}, 64'(ovl), 64'd0);
        chk({tag, "_dds_start_cycles"}, 64'(ds_cnt), 64'((typ != 0) ? total : n * ti));
        if (inject_wr) chk({tag, "_req_during_burst"}, 64'(req_cnt), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        int c0, e_ok, e_ok2, c_ack, k, iz_c, pr_c, ds_c, ovl;

        tbl[0] = '{48'h10_0000_0000, 48'h10_0000, 32'h100, 0, 0, 5, 5, 5, 5, 0, 0, 0};
        tbl[1] = '{48'h00_0012_3456, 48'h55, 32'h7, 1, 0, 3, 2, 4, 1, 3, 4, 3};
        tbl[2] = '{48'hFFFF_FFFF_FFFF, 48'h1, 32'hFFFF_FFFF, 3, 1, 2, 0, 3, 2, 6, 9, 21};
        tbl[3] = '{48'h1, 48'h2, 32'h3, 2, 0, 0, 2, 3, 1, 0, 6, 0};
        tbl[4] = '{48'h8000_0000_0000, 48'h0, 32'h0, 2, 2, 4, 1, 0, 0, 8, 0, 10};
        tbl[5] = '{48'h5, 48'h5, 32'h5, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{48'h7, 48'h8, 32'h9, 1, 3, 1, 0, 1, 0, 1, 1, 2};

        RESET = 1'b0; SYS_TIME = 64'd0; SYS_TIME_UPDATE = 1'b0; T1hz = 1'b0; WR_DATA = 1'b0;
        MEM_DDS_freq = '0; MEM_DDS_delta_freq = '0; MEM_DDS_delta_rate = '0; MEM_TIME_START = '0;
        MEM_N_impuls = '0; MEM_TYPE_impulse = '0; MEM_Interval_Ti = '0; MEM_Interval_Tp = '0;
        MEM_Tblank1 = '0; MEM_Tblank2 = '0; ACK = 1'b0;

        repeat (3) @(negedge CLK);
        chk("rst_req", 64'(REQ), 64'd0);
        chk("rst_dds_start", 64'(DDS_start), 64'd0);
        chk("rst_en_iz", 64'(En_Iz), 64'd0);
        chk("rst_en_pr", 64'(En_Pr), 64'd0);
        chk("rst_ok", 64'(SYS_TIME_UPDATE_OK), 64'd0);
        chk("rst_dds_freq", 64'(DDS_freq), 64'd0);
        chk("rst_dds_dfreq", 64'(DDS_delta_freq), 64'd0);
        chk("rst_dds_rate", 64'(DDS_delta_rate), 64'd0);
        RESET = 1'b1;

        // Preset system time to 0 on a 1 Hz mark.
        repeat (2) @(negedge CLK);
        SYS_TIME = 64'd0; SYS_TIME_UPDATE = 1'b1; T1hz = 1'b1;
        c0 = cyc;
        k = 0;
        while (SYS_TIME_UPDATE_OK !== 1'b1 && k < 10) begin @(negedge CLK); k++; end
        e_ok = cyc;
        chk("preset_ok_set", 64'(SYS_TIME_UPDATE_OK), 64'd1);
        chk("preset_ok_latency", 64'(e_ok - c0), 64'd3);
        repeat (3) @(negedge CLK);
        chk("preset_ok_hold", 64'(SYS_TIME_UPDATE_OK), 64'd1);
        SYS_TIME_UPDATE = 1'b0;
        @(negedge CLK);
        chk("preset_ok_clear", 64'(SYS_TIME_UPDATE_OK), 64'd0);

        // Descriptor table: start times in the past, count window outputs.
        for (int i = 0; i < 7; i++) begin
            do_write($sformatf("tbl%0d", i), tbl[i].freq, tbl[i].dfreq, tbl[i].rate, 64'd0,
                     tbl[i].n, tbl[i].typ, tbl[i].ti, tbl[i].b1, tbl[i].tp, tbl[i].b2, c_ack);
            iz_c = 0; pr_c = 0; ds_c = 0; ovl = 0;
            for (int j = 0; j < 60; j++) begin
                if (En_Iz) iz_c++;
                if (En_Pr) pr_c++;
                if (DDS_start) ds_c++;
                if (En_Iz && En_Pr) ovl++;
                @(negedge CLK);
            end
            chk($sformatf("tbl%0d_en_iz_cycles", i), 64'(iz_c), 64'(tbl[i].exp_iz));
            chk($sformatf("tbl%0d_en_pr_cycles", i), 64'(pr_c), 64'(tbl[i].exp_pr));
            chk($sformatf("tbl%0d_dds_start_cycles", i), 64'(ds_c), 64'(tbl[i].exp_ds));
            chk($sformatf("tbl%0d_overlap", i), 64'(ovl), 64'd0);
        end

        // Coherent burst at absolute time 0x12C0.
        do_write("t3", 48'h10_0000_0000, 48'h10_0000, 32'h100, 64'h12C0, 2, 1,
                 32'h1800, 32'h180, 32'h1800, 32'h180, c_ack);
        check_burst("t3", e_ok + 32'h12C0 + 1, 2, 1, 32'h1800, 32'h180, 32'h1800, 32'h180, 1'b0);

        // Second preset near the next start time, then a non-coherent burst with a write injected.
        T1hz = 1'b0;
        repeat (4) @(negedge CLK);
        SYS_TIME = 64'h13000; SYS_TIME_UPDATE = 1'b1; T1hz = 1'b1;
        k = 0;
        while (SYS_TIME_UPDATE_OK !== 1'b1 && k < 10) begin @(negedge CLK); k++; end
        e_ok2 = cyc;
        chk("preset2_ok_set", 64'(SYS_TIME_UPDATE_OK), 64'd1);
        SYS_TIME_UPDATE = 1'b0;
        do_write("t4", 48'h20_0000_0000, 48'h20_0000, 32'h200, 64'h1380B, 4, 0,
                 32'h800, 32'h80, 32'h800, 32'h80, c_ack);
        check_burst("t4", e_ok2 + 32'h80B + 1, 4, 0, 32'h800, 32'h80, 32'h800, 32'h80, 1'b1);
        chk("t5_wr_ignored_freq", 64'(DDS_freq), 64'h20_0000_0000);

        // Start time already passed: burst begins right after the handshake.
        do_write("t6", 48'h33, 48'h44, 32'h55, 64'h13000, 2, 0, 10, 3, 7, 2, c_ack);
        check_burst("t6", c_ack + 4, 2, 0, 10, 3, 7, 2, 1'b0);

        // Asynchronous reset in the middle of a burst.
        do_write("t7", 48'h66, 48'h77, 32'h88, 64'd0, 3, 1, 50, 5, 50, 5, c_ack);
        repeat (24) @(negedge CLK);
        chk("t7_burst_active", 64'(En_Iz), 64'd1);
        RESET = 1'b0;
        #1;
        chk("t7_rst_en_iz", 64'(En_Iz), 64'd0);
        chk("t7_rst_dds_start", 64'(DDS_start), 64'd0);
        chk("t7_rst_dds_freq", 64'(DDS_freq), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        iz_c = 0;
        for (int j = 0; j < 200; j++) begin
            if (En_Iz || En_Pr || DDS_start || REQ) iz_c++;
            @(negedge CLK);
        end
        chk("t7_burst_lost", 64'(iz_c), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
